// File: rtl/credit_pkg.sv
// Shared types and helpers for the credit-gated round-robin arbiter.
package credit_pkg;

    // Controller phases: one idle cycle after reset, normal issue, and
    // waiting for the downstream receiver to hand a credit back.
    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } ctrl_state_e;

    // Index that follows idx in a ring of n entries.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin pick: scan the request vector starting at ptr, wrapping
// modulo N_REQ; the first requester found wins.
module rr_select #(
    parameter  int N_REQ = 4,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    idx,
    output logic             any
);

    logic [IW:0] cand;

    // Priority walk from ptr upward; the one extra bit absorbs the wrap.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr} + (IW+1)'(i);
            if (cand >= (IW+1)'(N_REQ))
                cand = cand - (IW+1)'(N_REQ);
            if (!any && req[cand[IW-1:0]]) begin
                any                = 1'b1;
                idx                = cand[IW-1:0];
                gnt[cand[IW-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/credit_rr_arbiter.sv
// Credit-gated round-robin arbiter feeding a downstream credit FIFO.
// Grants are issued combinationally (o_req_ack) and the winning payload is
// registered toward the FIFO one cycle later.
module credit_rr_arbiter
    import credit_pkg::*;
#(
    parameter  int DATA_WIDTH = 17,
    parameter  int N_REQ      = 4,
    parameter  int FIFO_ADDR  = 3,
    localparam int IW         = $clog2(N_REQ),
    localparam int N_CREDITS  = 2**FIFO_ADDR
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            i_req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [N_REQ-1:0]            o_req_ack,
    output logic                        o_valid,
    output logic [DATA_WIDTH-1:0]       o_data,
    output logic [IW-1:0]               o_grant_id,
    input  logic                        i_increment_count,
    output logic [FIFO_ADDR:0]          o_credits,
    output logic                        o_credit_error
);

    localparam logic [FIFO_ADDR:0] CRED_MAX = (FIFO_ADDR+1)'(N_CREDITS);

    ctrl_state_e                         state, state_nxt;
    logic [FIFO_ADDR:0]                  credits, credits_nxt;
    logic [IW-1:0]                       ptr;
    logic [N_REQ-1:0]                    sel_gnt;
    logic [IW-1:0]                       sel_idx;
    logic                                sel_any;
    logic                                grant;
    logic                                overflow;
    logic [N_REQ-1:0][DATA_WIDTH-1:0]    req_data;

    assign req_data = i_req_data;

    rr_select #(.N_REQ(N_REQ)) u_sel (
        .req (i_req_valid),
        .ptr (ptr),
        .gnt (sel_gnt),
        .idx (sel_idx),
        .any (sel_any)
    );

    // A grant needs an issuing phase, a free credit and somebody asking.
    // STALL implies zero credits, so checking RUN covers it.
    always_comb begin
        grant     = (state == RUN) && (credits != '0) && sel_any;
        o_req_ack = grant ? sel_gnt : '0;
        overflow  = i_increment_count && !grant && (credits == CRED_MAX);
    end

    // Credit bookkeeping: grant and return in one cycle cancel out; a return
    // into a full pool is dropped (saturate) and flagged.
    always_comb begin
        credits_nxt = credits;
        if (grant && !i_increment_count)
            credits_nxt = credits - 1'b1;
        else if (!grant && i_increment_count && !overflow)
            credits_nxt = credits + 1'b1;
    end

    // Controller next state.
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    state_nxt = RUN;
            RUN:     if (credits_nxt == '0) state_nxt = STALL;
            STALL:   if (i_increment_count) state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
    end

    // Controller, credit pool, rotation pointer and sticky error.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= INIT;
            credits        <= CRED_MAX;
            ptr            <= '0;
            o_credit_error <= 1'b0;
        end else begin
            state   <= state_nxt;
            credits <= credits_nxt;
            if (grant)
                ptr <= IW'(rr_next(32'(sel_idx), N_REQ));
            if (overflow)
                o_credit_error <= 1'b1;
        end
    end

    // Registered enqueue toward the FIFO; payload and id hold between grants.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_grant_id <= '0;
        end else begin
            o_valid <= grant;
            if (grant) begin
                o_data     <= req_data[sel_idx];
                o_grant_id <= sel_idx;
            end
        end
    end

    assign o_credits = credits;

endmodule
